instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: writable program memory, fetch PC, instruction register, jump flush.
// Optional IFU_FETCH_CNT_EN adds a saturating fetch_cnt output.
module instr_fetch_unit #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               run,
    input  logic               stall,
    input  logic               jumpSelect,
    output logic [2:0]         opcode,
    output logic               rs,
    output logic               rd,
    output logic [2:0]         imm,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    output logic               halted
`ifdef IFU_FETCH_CNT_EN
    ,
    output logic [15:0]        fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH,
        HALTED
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [INSTR_W-1:0] memWord;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] irNext;
    logic [ADDR_W-1:0]  fpc;
    logic [ADDR_W-1:0]  fpcNext;
    logic [ADDR_W-1:0]  pcNext;
    logic               validNext;
    logic               doFetch;

    // Program memory is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign memWord = mem[fpc];

    always_comb begin
        stateNext = state;
        fpcNext   = fpc;
        irNext    = ir;
        pcNext    = pc;
        validNext = instr_valid;
        doFetch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!stall && run) begin
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                if (!stall) begin
                    if (instr_valid && jumpSelect) begin
                        validNext = 1'b0;
                        fpcNext   = ADDR_W'(ir[2:0]);
                        stateNext = FLUSH;
                    end else if (instr_valid && (ir == '1)) begin
                        validNext = 1'b0;
                        stateNext = HALTED;
                    end else if (!run) begin
                        validNext = 1'b0;
                        stateNext = IDLE;
                    end else begin
                        doFetch = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    doFetch   = 1'b1;
                    stateNext = FETCH;
                end
            end
            HALTED: begin
                validNext = 1'b0;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (doFetch) begin
            irNext    = memWord;
            pcNext    = fpc;
            fpcNext   = fpc + ADDR_W'(1);
            validNext = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            fpc         <= '0;
            ir          <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= stateNext;
            fpc         <= fpcNext;
            ir          <= irNext;
            pc          <= pcNext;
            instr_valid <= validNext;
        end
    end

`ifdef IFU_FETCH_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_cnt <= '0;
        end else if (doFetch && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

    assign opcode = ir[7:5];
    assign rs     = ir[4];
    assign rd     = ir[3];
    assign imm    = ir[2:0];
    assign halted = (state == HALTED);

endmodule
